actmem_bank_array: RTL and testbench

- Multi-bank activation memory for the layer datapath. It replaces the single-bank behavioural activation SRAM.
- NUM_BANKS independent single-port banks, each with its own request, write-enable, address, bit-enable and data.
- Configurable read latency (1 or 2 cycles), an explicit per-bank rvalid, a selectable read-data hold policy, and a hardware zero-fill (clear) engine.
- Sits between the layer controller/OCU writeback and the linebuffer fill path.

---
 rtl/actmem_bank_array.sv | 170 +++++++++++++++++
 tb/tb_actmem_bank_array.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/actmem_bank_array.sv
// actmem_bank_array: NUM_BANKS independent single-port activation banks with a
// 1- or 2-cycle registered read path, per-bank rvalid, an optional read-data
// hold, and a zero-fill engine that sweeps every word of every bank.
module actmem_bank_array #(
  parameter int NUM_BANKS    = 6,
  parameter int DATA_WIDTH   = 40,
  parameter int NUM_WORDS    = 1024,
  parameter int ADDR_WIDTH   = $clog2(NUM_WORDS),
  parameter int READ_LATENCY = 1,
  parameter bit HOLD_RDATA   = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  output logic                             busy_o,
  input  logic [NUM_BANKS-1:0]             req_i,
  input  logic [NUM_BANKS-1:0]             we_i,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  be_i,
  output logic [NUM_BANKS-1:0]             gnt_o,
  output logic [NUM_BANKS-1:0]             rvalid_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  rdata_o
);

  // Illegal configurations stop elaboration.
  if ((READ_LATENCY != 1 && READ_LATENCY != 2) || NUM_BANKS < 1 || NUM_WORDS < 2) begin : g_param_check
    $error("actmem_bank_array: READ_LATENCY must be 1 or 2, NUM_BANKS >= 1, NUM_WORDS >= 2");
  end

  // One extra bit so NUM_WORDS itself is representable when it is a power of two.
  localparam logic [ADDR_WIDTH:0]   WORDS_EXT = (ADDR_WIDTH+1)'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_next;
  logic                  busy;

  // Bit-enabled merge of new data into an existing word.
  function automatic logic [DATA_WIDTH-1:0] merge_bits(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [DATA_WIDTH-1:0] mask
  );
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  assign busy   = (state == ST_CLEAR);
  assign busy_o = busy;
  assign gnt_o  = req_i & {NUM_BANKS{~busy}};

  // Zero-fill FSM state and sweep counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= {ADDR_WIDTH{1'b0}};
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: start on clear_i when idle, stop after the last word.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (clear_i) begin
          state_next = ST_CLEAR;
          cnt_next   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_next = ST_IDLE;
          cnt_next   = {ADDR_WIDTH{1'b0}};
        end
      end
      ST_CLEAR: begin
        if (cnt == LAST_WORD) begin
          state_next = ST_IDLE;
          cnt_next   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_next = ST_CLEAR;
          cnt_next   = cnt + ADDR_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] be;
    logic                  in_range;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    assign addr     = addr_i[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata    = wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    assign be       = be_i[b*DATA_WIDTH +: DATA_WIDTH];
    assign in_range = ({1'b0, addr} < WORDS_EXT);
    // Out-of-range writes vanish; nothing is written while reset is applied.
    assign wr_en    = gnt_o[b] & we_i[b] & in_range & ~rst_i;
    assign rd_en    = gnt_o[b] & ~we_i[b];
    // Out-of-range reads return zero instead of aliasing onto a real word.
    assign rd_word  = in_range ? mem[addr] : {DATA_WIDTH{1'b0}};

    // Array update: zero-fill sweep has priority (requests are not granted then).
    always_ff @(posedge clk_i) begin
      if (busy && !rst_i) begin
        mem[cnt] <= {DATA_WIDTH{1'b0}};
      end else if (wr_en) begin
        mem[addr] <= merge_bits(mem[addr], wdata, be);
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      // Extra read stage: the word is captured at the end of the request cycle,
      // so a write in the following cycle cannot disturb it.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          pipe_valid <= 1'b0;
          pipe_data  <= {DATA_WIDTH{1'b0}};
        end else begin
          pipe_valid <= rd_en;
          pipe_data  <= rd_en ? rd_word : {DATA_WIDTH{1'b0}};
        end
      end
    end else begin : g_lat1
      assign pipe_valid = rd_en;
      assign pipe_data  = rd_word;
    end

    // Output register: rvalid pulse plus hold-or-zero read data.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rvalid <= 1'b0;
        rdata  <= {DATA_WIDTH{1'b0}};
      end else begin
        rvalid <= pipe_valid;
        if (pipe_valid) begin
          rdata <= pipe_data;
        end else if (!HOLD_RDATA) begin
          rdata <= {DATA_WIDTH{1'b0}};
        end
      end
    end

    assign rvalid_o[b]                          = rvalid;
    assign rdata_o[b*DATA_WIDTH +: DATA_WIDTH]  = rdata;
  end

endmodule

// File: tb/tb_actmem_bank_array.sv
// Bench for actmem_bank_array: two instances (LAT=1/HOLD=1/1024 words and
// LAT=2/HOLD=0/1000 words) share one stimulus stream; an array-based model
// predicts busy, grant, rvalid and rdata for each every cycle.
module tb_actmem_bank_array;
  localparam int NB = 6;
  localparam int DW = 40;
  localparam int AW = 10;
  localparam int CW = NB*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               clear;
  logic [NB-1:0]      req;
  logic [NB-1:0]      we;
  logic [NB*AW-1:0]   addr;
  logic [NB*DW-1:0]   wdata;
  logic [NB*DW-1:0]   be;

  logic               busy_w [2];
  logic [NB-1:0]      gnt_w  [2];
  logic [NB-1:0]      rv_w   [2];
  logic [NB*DW-1:0]   rd_w   [2];

  int errors = 0;
  int checks = 0;

  actmem_bank_array #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .NUM_WORDS(1024),
                      .READ_LATENCY(1), .HOLD_RDATA(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy_w[0]),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt_w[0]), .rvalid_o(rv_w[0]), .rdata_o(rd_w[0]));

  actmem_bank_array #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .NUM_WORDS(1000),
                      .READ_LATENCY(2), .HOLD_RDATA(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy_w[1]),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt_w[1]), .rvalid_o(rv_w[1]), .rdata_o(rd_w[1]));

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nw_of(input int k);
    return (k == 0) ? 1024 : 1000;
  endfunction
  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mm   [2][NB][1024];
  int            busy_left [2];
  bit            sv   [2][NB][4];
  logic [DW-1:0] sd   [2][NB][4];
  logic          ev   [2][NB];
  logic [DW-1:0] ed   [2][NB];
  int            cyc = 0;
  bit            model_ok = 1'b0;
  int            m_a;
  int            m_slot;
  logic [DW-1:0] m_d;
  logic [DW-1:0] m_m;

  initial begin
    for (int k = 0; k < 2; k++) begin
      busy_left[k] = 0;
      for (int b = 0; b < NB; b++) begin
        ev[k][b] = 1'b0;
        ed[k][b] = '0;
        for (int s = 0; s < 4; s++) begin
          sv[k][b][s] = 1'b0;
          sd[k][b][s] = '0;
        end
        for (int w = 0; w < 1024; w++) mm[k][b][w] = '0;
      end
    end
  end

  // Model step at each rising edge, using the inputs of the cycle just ending.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy_left[k] = 0;
        for (int b = 0; b < NB; b++) begin
          ev[k][b] = 1'b0;
          ed[k][b] = '0;
          for (int s = 0; s < 4; s++) sv[k][b][s] = 1'b0;
        end
      end else begin
        if (busy_left[k] != 0) begin
          for (int b = 0; b < NB; b++) mm[k][b][nw_of(k) - busy_left[k]] = '0;
          busy_left[k] = busy_left[k] - 1;
        end else begin
          for (int b = 0; b < NB; b++) begin
            if (req[b]) begin
              m_a = int'(addr[b*AW +: AW]);
              if (we[b]) begin
                if (m_a < nw_of(k)) begin
                  m_d = wdata[b*DW +: DW];
                  m_m = be[b*DW +: DW];
                  for (int i = 0; i < DW; i++)
                    if (m_m[i]) mm[k][b][m_a][i] = m_d[i];
                end
              end else begin
                m_slot = (cyc + lat_of(k)) % 4;
                sv[k][b][m_slot] = 1'b1;
                sd[k][b][m_slot] = (m_a < nw_of(k)) ? mm[k][b][m_a] : '0;
              end
            end
          end
          if (clear) busy_left[k] = nw_of(k);
        end
        m_slot = (cyc + 1) % 4;
        for (int b = 0; b < NB; b++) begin
          if (sv[k][b][m_slot]) begin
            ev[k][b] = 1'b1;
            ed[k][b] = sd[k][b][m_slot];
            sv[k][b][m_slot] = 1'b0;
          end else begin
            ev[k][b] = 1'b0;
            if (k != 0) ed[k][b] = '0;
          end
        end
      end
    end
    if (rst) model_ok = 1'b1;
    cyc++;
  end

  logic [NB-1:0]    e_gnt;
  logic [NB-1:0]    e_rv;
  logic [NB*DW-1:0] e_rd;

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        e_gnt = (busy_left[k] != 0) ? '0 : req;
        for (int b = 0; b < NB; b++) begin
          e_rv[b] = ev[k][b];
          e_rd[b*DW +: DW] = ed[k][b];
        end
        check($sformatf("busy%0d", k),   CW'(busy_w[k]), CW'(busy_left[k] != 0));
        check($sformatf("gnt%0d", k),    CW'(gnt_w[k]),  CW'(e_gnt));
        check($sformatf("rvalid%0d", k), CW'(rv_w[k]),   CW'(e_rv));
        check($sformatf("rdata%0d", k),  rd_w[k],        e_rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
    req   = '0;
    we    = '0;
    clear = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic acc(input int b, input bit w, input int a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    req[b] = 1'b1;
    we[b]  = w;
    addr[b*AW +: AW] = a[AW-1:0];
    wdata[b*DW +: DW] = d;
    be[b*DW +: DW] = m;
  endtask

  task automatic all_acc(input bit w, input int a, input logic [DW-1:0] d);
    for (int b = 0; b < NB; b++) acc(b, w, a, d, {DW{1'b1}});
  endtask

  logic [DW-1:0] ones;
  logic [63:0]   r64;
  int            n0;
  int            n1;
  int            sel;

  initial begin
    ones  = {DW{1'b1}};
    rst   = 1'b1;
    clear = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rvalid", CW'(rv_w[0]), CW'(6'b000000));
    check("reset_rdata",  rd_w[0], {CW{1'b0}});
    check("reset_busy",   CW'(busy_w[0]), CW'(1'b0));

    // Full zero-fill; early requests during busy must be dropped.
    nxt(); clear = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 1100; i++) begin
      nxt();
      if (i < 4) begin
        req = '1;
        we  = 6'b101010;
      end
      @(negedge clk);
      if (busy_w[0]) n0++;
      if (busy_w[1]) n1++;
    end
    check("busy_len0", CW'(n0), CW'(1024));
    check("busy_len1", CW'(n1), CW'(1000));

    // Post-clear reads of the first and last word.
    nxt(); all_acc(1'b0, 0, '0);
    nxt(); all_acc(1'b0, 1023, '0);
    @(negedge clk);
    check("clr_rd0_valid", CW'(rv_w[0]), CW'(6'b111111));
    check("clr_rd0_data",  rd_w[0], {CW{1'b0}});
    nxt(); nxt(); nxt();

    // Write then read, LAT=1 and LAT=2, with hold behaviour.
    nxt(); acc(0, 1'b1, 5, 40'hAB_CDEF_0123, ones);
    nxt(); acc(0, 1'b0, 5, '0, ones);
    nxt(); @(negedge clk);
    check("wr_rd_valid0", CW'(rv_w[0][0]), CW'(1'b1));
    check("wr_rd_data0",  CW'(rd_w[0][DW-1:0]), CW'(40'hAB_CDEF_0123));
    check("lat2_not_yet", CW'(rv_w[1][0]), CW'(1'b0));
    nxt(); @(negedge clk);
    check("hold_valid0",  CW'(rv_w[0][0]), CW'(1'b0));
    check("hold_data0",   CW'(rd_w[0][DW-1:0]), CW'(40'hAB_CDEF_0123));
    check("lat2_data1",   CW'(rd_w[1][DW-1:0]), CW'(40'hAB_CDEF_0123));
    nxt(); @(negedge clk);
    check("nohold_data1", CW'(rd_w[1][DW-1:0]), CW'(40'h0));

    // Bit-enable mask.
    nxt(); acc(0, 1'b1, 6, ones, ones);
    nxt(); acc(0, 1'b1, 6, 40'h0, 40'h00_0000_FFFF);
    nxt(); acc(0, 1'b0, 6, '0, ones);
    nxt(); @(negedge clk);
    check("bitmask0", CW'(rd_w[0][DW-1:0]), CW'(40'hFF_FFFF_0000));
    nxt();

    // Pipelined reads of addrs 0..3; bank 0 rewrites addr 1 right after reading it.
    for (int a = 0; a < 4; a++) begin
      nxt();
      for (int b = 0; b < NB; b++) acc(b, 1'b1, a, 40'h10_0000_0000 | DW'(b << 8) | DW'(a), ones);
    end
    nxt(); all_acc(1'b0, 0, '0);
    nxt(); all_acc(1'b0, 1, '0);
    nxt(); all_acc(1'b0, 2, '0); acc(0, 1'b1, 1, 40'h12_3456_789A, ones);
    @(negedge clk);
    check("pipe_a0_b0", CW'(rd_w[1][DW-1:0]), CW'(40'h10_0000_0000));
    nxt(); all_acc(1'b0, 3, '0);
    @(negedge clk);
    check("pipe_a1_old", CW'(rd_w[1][DW-1:0]), CW'(40'h10_0000_0001));
    check("pipe_a1_b5",  CW'(rd_w[1][5*DW +: DW]), CW'(40'h10_0000_0501));
    nxt(); nxt(); nxt(); acc(0, 1'b0, 1, '0, ones);
    nxt(); @(negedge clk);
    check("pipe_a1_new", CW'(rd_w[0][DW-1:0]), CW'(40'h12_3456_789A));
    nxt(); nxt();

    // Out-of-range for the 1000-word instance; no aliasing onto 986.
    nxt(); all_acc(1'b1, 986, 40'h55_0000_0986);
    nxt(); all_acc(1'b1, 1010, 40'hEE_EEEE_EEEE);
    nxt(); all_acc(1'b0, 1010, '0);
    nxt(); @(negedge clk);
    check("oor_inrange0", CW'(rd_w[0][DW-1:0]), CW'(40'hEE_EEEE_EEEE));
    nxt(); all_acc(1'b0, 986, '0);
    @(negedge clk);
    check("oor_valid1", CW'(rv_w[1]), CW'(6'b111111));
    check("oor_data1",  rd_w[1], {CW{1'b0}});
    nxt(); nxt(); @(negedge clk);
    check("oor_noalias1", CW'(rd_w[1][DW-1:0]), CW'(40'h55_0000_0986));

    // Reset in clear cycle 10: words 0..9 zeroed, the rest untouched.
    nxt(); all_acc(1'b1, 3, 40'h33_0000_0003);
    nxt(); all_acc(1'b1, 500, 40'h77_0000_0500);
    nxt(); clear = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      nxt();
      if (i == 10) rst = 1'b1;
    end
    nxt(); @(negedge clk);
    check("abort_busy0", CW'(busy_w[0]), CW'(1'b0));
    check("abort_busy1", CW'(busy_w[1]), CW'(1'b0));
    nxt(); all_acc(1'b0, 3, '0);
    nxt(); all_acc(1'b0, 500, '0);
    @(negedge clk);
    check("abort_a3", CW'(rd_w[0][DW-1:0]), CW'(40'h0));
    nxt(); @(negedge clk);
    check("abort_a500", CW'(rd_w[0][DW-1:0]), CW'(40'h77_0000_0500));
    nxt(); nxt();

    // Randomized mixed traffic across all banks.
    for (int c = 0; c < 3000; c++) begin
      nxt();
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 3) != 0) begin
          req[b] = 1'b1;
          we[b]  = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 9) == 0) addr[b*AW +: AW] = AW'(1000 + $urandom_range(0, 23));
          else                           addr[b*AW +: AW] = AW'($urandom_range(0, 15));
          r64 = {$urandom, $urandom};
          wdata[b*DW +: DW] = r64[DW-1:0];
          sel = $urandom_range(0, 3);
          r64 = {$urandom, $urandom};
          if (sel == 0)      be[b*DW +: DW] = ones;
          else if (sel == 1) be[b*DW +: DW] = '0;
          else               be[b*DW +: DW] = r64[DW-1:0];
        end
      end
    end
    repeat (4) nxt();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
